// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - MSB-first parallel-to-serial front end with valid/ready word load
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   load_data    WIDTH-bit word, sampled only on an accepted load
//   load_valid   upstream offers a word
//   load_ready   a word can be accepted this cycle (decoded from registered state)
//   serial_out   registered serial line, MSB first; IDLE_BIT between words
//   serial_valid registered flag: serial_out carries a word bit
//   busy         a word is being shifted (same as serial_valid)
//   word_done    high while the LSB of a word is on serial_out
module seq_bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             word_done
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             out_nxt;
    logic             valid_nxt;
    logic             on_last;
    logic             accept;

    // The LSB is on the line exactly when the counter has reached its last value.
    assign on_last    = (state == ST_SHIFT) && (cnt == LAST);
    assign load_ready = (state == ST_IDLE) || on_last;
    assign word_done  = on_last;
    assign busy       = serial_valid;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            sr           <= '0;
            cnt          <= '0;
            serial_out   <= IDLE_BIT;
            serial_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            sr           <= sr_nxt;
            cnt          <= cnt_nxt;
            serial_out   <= out_nxt;
            serial_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        out_nxt   = serial_out;
        valid_nxt = serial_valid;
        if (accept) begin
            // Loading on the last-bit edge chains the next MSB straight after the LSB.
            state_nxt = ST_SHIFT;
            sr_nxt    = load_data;
            cnt_nxt   = '0;
            out_nxt   = load_data[WIDTH-1];
            valid_nxt = 1'b1;
        end else if (state == ST_SHIFT) begin
            if (cnt == LAST) begin
                state_nxt = ST_IDLE;
                out_nxt   = IDLE_BIT;
                valid_nxt = 1'b0;
            end else begin
                // Rotate rather than shift in zeros: the top bit only ever feeds the
                // line via the next position, and nothing reads the bits wrapped below.
                sr_nxt  = {sr[WIDTH-2:0], sr[WIDTH-1]};
                cnt_nxt = cnt + ONE;
                out_nxt = sr[WIDTH-2];
            end
        end
    end
endmodule
